// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshake bundle for serial_add_ctrl.
// The producer/consumer side uses master; the adder uses slave.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Serial a+b+cin adder: one 2-bit slice per cycle, LSB chunk first,
// carry recirculated through a flop; valid/ready on both sides.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_add_ctrl_if.slave io,
   output logic           busy
);
   localparam int CHUNKS = WIDTH / 2;
   localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
         $error("serial_add_ctrl: WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [2:0]       slice;
   logic [WIDTH+1:0] sum_cat;
   logic             last;

   assign slice = {1'b0, a_sh_q[1:0]}
                + {1'b0, b_sh_q[1:0]}
                + {2'b00, carry_q};
   // New chunk enters at the MSB end; after CHUNKS steps chunk 0 sits at [1:0].
   assign sum_cat = {slice[1:0], sum_q};
   assign last = (cnt_q == CW'(CHUNKS - 1));

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               a_sh_d     = io.in_a;
               b_sh_d     = io.in_b;
               carry_d    = io.in_cin;
               cnt_d      = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 2;
            b_sh_d  = b_sh_q >> 2;
            sum_d   = sum_cat[WIDTH+1:2];
            carry_d = slice[2];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
               cout_d      = slice[2];
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (io.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.out_sum   = sum_q;
   assign io.out_cout  = cout_q;
   assign busy         = busy_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
// Scoreboard queues fill on accept and drain on result handshake.
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic busy8, busy2;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8)) ifc8 ();
   serial_add_ctrl_if #(.WIDTH(2)) ifc2 ();

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifc8.slave),
      .busy  (busy8)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifc2.slave),
      .busy  (busy2)
   );

   int vectors = 0;
   int miscompares = 0;
   int acc8 = 0;
   int acc2 = 0;
   logic [8:0] q8[$];
   logic [2:0] q2[$];

   task automatic mon8();
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q8.delete();
         end else begin
            if (ifc8.in_valid && ifc8.in_ready) begin
               q8.push_back({1'b0, ifc8.in_a} + {1'b0, ifc8.in_b}
                            + {8'd0, ifc8.in_cin});
               acc8++;
            end
            if (ifc8.out_valid && ifc8.out_ready) begin
               vectors++;
               if (q8.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb8_unexpected got=%h exp=none",
                           {ifc8.out_cout, ifc8.out_sum});
               end else begin
                  e = q8.pop_front();
                  if ({ifc8.out_cout, ifc8.out_sum} !== e) begin
                     miscompares++;
                     $display("FAIL sb8_result got=%h exp=%h",
                              {ifc8.out_cout, ifc8.out_sum}, e);
                  end
               end
            end
         end
      end
   endtask

   task automatic mon2();
      logic [2:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q2.delete();
         end else begin
            if (ifc2.in_valid && ifc2.in_ready) begin
               q2.push_back({1'b0, ifc2.in_a} + {1'b0, ifc2.in_b}
                            + {2'd0, ifc2.in_cin});
               acc2++;
            end
            if (ifc2.out_valid && ifc2.out_ready) begin
               vectors++;
               if (q2.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb2_unexpected got=%h exp=none",
                           {ifc2.out_cout, ifc2.out_sum});
               end else begin
                  e = q2.pop_front();
                  if ({ifc2.out_cout, ifc2.out_sum} !== e) begin
                     miscompares++;
                     $display("FAIL sb2_result got=%h exp=%h",
                              {ifc2.out_cout, ifc2.out_sum}, e);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({ifc8.in_ready, ifc8.out_valid, ifc8.out_sum, ifc8.out_cout, busy8}
          !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset8_in got=%b exp=%b",
                  {ifc8.in_ready, ifc8.out_valid, ifc8.out_sum,
                   ifc8.out_cout, busy8}, 12'b1_0_00000000_0_0);
      end
      vectors++;
      if ({ifc2.in_ready, ifc2.out_valid, ifc2.out_sum, ifc2.out_cout, busy2}
          !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset2_in got=%b exp=%b",
                  {ifc2.in_ready, ifc2.out_valid, ifc2.out_sum,
                   ifc2.out_cout, busy2}, 6'b1_0_00_0_0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if ({ifc8.in_ready, ifc8.out_valid, busy8} !== 3'b100) begin
         miscompares++;
         $display("FAIL reset8_after got=%b exp=%b",
                  {ifc8.in_ready, ifc8.out_valid, busy8}, 3'b100);
      end
   endtask

   task automatic test_basic(input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input logic [7:0] es,
                             input logic ec);
      int cyc;
      ifc8.in_a = a;
      ifc8.in_b = b;
      ifc8.in_cin = cin;
      ifc8.in_valid = 1'b1;
      ifc8.out_ready = 1'b0;
      @(posedge clk);
      #1;
      ifc8.in_valid = 1'b0;
      ifc8.in_a = 8'h00;
      ifc8.in_b = 8'h00;
      cyc = 0;
      while (!ifc8.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      vectors++;
      if (cyc !== 4) begin
         miscompares++;
         $display("FAIL basic_latency got=%0d exp=4", cyc);
      end
      vectors++;
      if ({ifc8.out_cout, ifc8.out_sum} !== {ec, es}) begin
         miscompares++;
         $display("FAIL basic_sum a=%h b=%h cin=%b got=%h exp=%h", a, b, cin,
                  {ifc8.out_cout, ifc8.out_sum}, {ec, es});
      end
      vectors++;
      if ({ifc8.in_ready, busy8} !== 2'b01) begin
         miscompares++;
         $display("FAIL basic_done_flags got=%b exp=01",
                  {ifc8.in_ready, busy8});
      end
      ifc8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc8.out_ready = 1'b0;
      vectors++;
      if ({ifc8.out_valid, ifc8.in_ready, busy8} !== 3'b010) begin
         miscompares++;
         $display("FAIL basic_release got=%b exp=010",
                  {ifc8.out_valid, ifc8.in_ready, busy8});
      end
   endtask

   task automatic test_stall();
      int cyc;
      int acc0;
      ifc8.in_a = 8'h12;
      ifc8.in_b = 8'h34;
      ifc8.in_cin = 1'b1;
      ifc8.in_valid = 1'b1;
      ifc8.out_ready = 1'b0;
      @(posedge clk);
      #1;
      ifc8.in_valid = 1'b0;
      acc0 = acc8;
      cyc = 0;
      while (!ifc8.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      for (int i = 0; i < 10; i++) begin
         ifc8.in_valid = ~ifc8.in_valid;
         ifc8.in_a = 8'($urandom);
         @(posedge clk);
         #1;
         vectors++;
         if ({ifc8.out_valid, ifc8.in_ready, ifc8.out_cout, ifc8.out_sum}
             !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d got=%b_%b_%b_%h exp=1_0_0_47", i,
                     ifc8.out_valid, ifc8.in_ready, ifc8.out_cout,
                     ifc8.out_sum);
         end
      end
      ifc8.in_valid = 1'b0;
      ifc8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc8.out_ready = 1'b0;
      vectors++;
      if (acc8 !== acc0) begin
         miscompares++;
         $display("FAIL stall_no_accept got=%0d exp=%0d", acc8, acc0);
      end
   endtask

   task automatic test_reset_mid_run();
      ifc8.in_a = 8'hAA;
      ifc8.in_b = 8'h55;
      ifc8.in_cin = 1'b0;
      ifc8.in_valid = 1'b1;
      ifc8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc8.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({ifc8.out_valid, ifc8.out_sum, ifc8.out_cout, ifc8.in_ready, busy8}
          !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL midrun_reset got=%b exp=%b",
                  {ifc8.out_valid, ifc8.out_sum, ifc8.out_cout,
                   ifc8.in_ready, busy8}, 12'b0_00000000_0_1_0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (q8.size() !== 0) begin
         miscompares++;
         $display("FAIL midrun_discard got=%0d exp=0", q8.size());
      end
      repeat (6) @(posedge clk);
      #1;
      vectors++;
      if (ifc8.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_no_valid got=%b exp=0", ifc8.out_valid);
      end
      ifc8.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc;
      int last_cyc;
      int last_acc;
      int n;
      ifc8.in_a = 8'($urandom);
      ifc8.in_b = 8'($urandom);
      ifc8.in_cin = 1'($urandom);
      ifc8.in_valid = 1'b1;
      ifc8.out_ready = 1'b1;
      last_acc = acc8;
      last_cyc = -1;
      n = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk);
         #1;
         if (acc8 != last_acc) begin
            last_acc = acc8;
            n++;
            if (last_cyc >= 0) begin
               vectors++;
               if (cyc - last_cyc !== 6) begin
                  miscompares++;
                  $display("FAIL b2b_interval got=%0d exp=6", cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            ifc8.in_a = 8'($urandom);
            ifc8.in_b = 8'($urandom);
            ifc8.in_cin = 1'($urandom);
         end
      end
      vectors++;
      if (n !== 7) begin
         miscompares++;
         $display("FAIL b2b_count got=%0d exp=7", n);
      end
      ifc8.in_valid = 1'b0;
      cyc = 0;
      while ((busy8 || q8.size() != 0) && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      ifc8.out_ready = 1'b0;
      vectors++;
      if (q8.size() !== 0) begin
         miscompares++;
         $display("FAIL b2b_drain got=%0d exp=0", q8.size());
      end
   endtask

   task automatic drive8(input int nops);
      int target;
      int cyc;
      target = acc8 + nops;
      cyc = 0;
      while (acc8 < target && cyc < 30000) begin
         @(posedge clk);
         #1;
         ifc8.in_valid = ($urandom_range(0, 9) < 7);
         ifc8.in_a = 8'($urandom);
         ifc8.in_b = 8'($urandom);
         ifc8.in_cin = 1'($urandom);
         ifc8.out_ready = ($urandom_range(0, 9) < 6);
         cyc++;
      end
      @(posedge clk);
      #1;
      ifc8.in_valid = 1'b0;
      ifc8.out_ready = 1'b1;
      cyc = 0;
      while ((busy8 || q8.size() != 0) && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      ifc8.out_ready = 1'b0;
      vectors++;
      if (acc8 !== target || q8.size() !== 0) begin
         miscompares++;
         $display("FAIL rand8_done got=%0d/%0d exp=%0d/0", acc8, q8.size(),
                  target);
      end
   endtask

   task automatic drive2(input int nops);
      int target;
      int cyc;
      target = acc2 + nops;
      cyc = 0;
      while (acc2 < target && cyc < 30000) begin
         @(posedge clk);
         #1;
         ifc2.in_valid = ($urandom_range(0, 9) < 7);
         ifc2.in_a = 2'($urandom);
         ifc2.in_b = 2'($urandom);
         ifc2.in_cin = 1'($urandom);
         ifc2.out_ready = ($urandom_range(0, 9) < 6);
         cyc++;
      end
      @(posedge clk);
      #1;
      ifc2.in_valid = 1'b0;
      ifc2.out_ready = 1'b1;
      cyc = 0;
      while ((busy2 || q2.size() != 0) && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      ifc2.out_ready = 1'b0;
      vectors++;
      if (acc2 !== target || q2.size() !== 0) begin
         miscompares++;
         $display("FAIL rand2_done got=%0d/%0d exp=%0d/0", acc2, q2.size(),
                  target);
      end
   endtask

   task automatic test_random();
      fork
         drive8(1000);
         drive2(1000);
      join
   endtask

   initial begin
      ifc8.in_valid = 1'b0;
      ifc8.in_a = '0;
      ifc8.in_b = '0;
      ifc8.in_cin = 1'b0;
      ifc8.out_ready = 1'b0;
      ifc2.in_valid = 1'b0;
      ifc2.in_a = '0;
      ifc2.in_b = '0;
      ifc2.in_cin = 1'b0;
      ifc2.out_ready = 1'b0;
      fork
         mon8();
         mon2();
      join_none
      test_reset();
      test_basic(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      test_basic(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      test_basic(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      test_stall();
      test_reset_mid_run();
      test_basic(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
